// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 encodings
// and the store byte-lane mask.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    // Unknown funct3 values fall through to a full-word access.
    function automatic logic [3:0] lane_mask(input logic [2:0] memop, input logic [1:0] off);
        logic [3:0] mask;
        case (memop)
            MEMOP_B, MEMOP_BU: mask = 4'b0001 << off;
            MEMOP_H, MEMOP_HU: mask = 4'b0011 << {off[1], 1'b0};
            default:           mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: picks the addressed byte/half out of the bus
// word and sign- or zero-extends it according to funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  memop,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        case (memop)
            MEMOP_B:  result = {{24{byte_sel[7]}}, byte_sel};
            MEMOP_BU: result = {24'd0, byte_sel};
            MEMOP_H:  result = {{16{half_sel[15]}}, half_sel};
            MEMOP_HU: result = {16'd0, half_sel};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core load/store, issues a single word-wide bus
// transfer and returns extended load data. Optional feature: LSU_MISALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          readMemEnable,
    input  logic          writeMemEnable,
    input  logic [2:0]    memOP,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wmask,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata
);

    lsu_state_t  state;
    logic        op_store;
    logic [2:0]  op_memop;
    logic [1:0]  op_off;
    logic [DW-1:0] load_result;
    logic        accept;

    function automatic logic [DW-1:0] store_data(input logic [2:0] memop, input logic [DW-1:0] d);
        logic [DW-1:0] lanes;
        case (memop)
            MEMOP_B, MEMOP_BU: lanes = {4{d[7:0]}};
            MEMOP_H, MEMOP_HU: lanes = {2{d[15:0]}};
            default:           lanes = d;
        endcase
        return lanes;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] memop, input logic [1:0] off);
        logic mis;
        case (memop)
            MEMOP_B, MEMOP_BU: mis = 1'b0;
            MEMOP_H, MEMOP_HU: mis = off[0];
            default:           mis = (off != 2'b00);
        endcase
        return mis;
    endfunction
`endif

    assign accept = req_valid && (readMemEnable || writeMemEnable);

    load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (op_off),
        .memop  (op_memop),
        .result (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wmask     <= 4'b0000;
            mem_wdata     <= '0;
            op_store      <= 1'b0;
            op_memop      <= 3'b000;
            op_off        <= 2'b00;
`ifdef LSU_MISALIGN_CHECK_EN
            resp_err      <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // A request with both enables set is handled as a store.
                        req_ready  <= 1'b0;
                        op_store   <= writeMemEnable;
                        op_memop   <= memOP;
                        op_off     <= addr[1:0];
                        resp_rdata <= '0;
                        mem_we     <= writeMemEnable;
                        mem_addr   <= {addr[AW-1:2], 2'b00};
                        mem_wmask  <= writeMemEnable ? lane_mask(memOP, addr[1:0]) : 4'b0000;
                        mem_wdata  <= writeMemEnable ? store_data(memOP, wdata) : '0;
`ifdef LSU_MISALIGN_CHECK_EN
                        resp_err   <= misaligned(memOP, addr[1:0]);
                        if (misaligned(memOP, addr[1:0])) begin
                            // Faulting accesses never reach the bus.
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            state         <= REQ;
                        end
`else
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        resp_rdata <= op_store ? '0 : load_result;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifndef LSU_MISALIGN_CHECK_EN
    assign resp_err = 1'b0;
`endif

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-side responder for the core's load/store control signals (`readMemEnable`, `writeMemEnable`, `memOP` = funct3). It accepts one load or store per request handshake and drives a word-wide data-bus master port. Stores get a byte mask and replicated lane data. Load data is lane-extracted and sign- or zero-extended before it returns to the write-back path. It sits between the execute stage (address = ALU result, store data = rs2) and the data memory or bus.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; fixed at 32, since lane logic is word-based

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  unit idle and able to accept a request
- `readMemEnable`  in  1  request is a load
- `writeMemEnable`  in  1  request is a store
- `memOP`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr`  in  AW  byte address
- `wdata`  in  32  store data (rs2)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data; 0 for stores
- `resp_err`  out  1  misaligned access; see Configuration
- `mem_req_valid`  out  1  bus request valid
- `mem_req_ready`  in  1  bus accepts the request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  AW  word-aligned address, `{addr[AW-1:2],2'b00}`
- `mem_wmask`  out  4  byte enables; 0 for reads
- `mem_wdata`  out  32  lane-replicated store data
- `mem_rsp_valid`  in  1  bus read-data or write ack
- `mem_rdata`  in  32  bus read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - A request is accepted when `req_valid` is high and (`readMemEnable` or `writeMemEnable`) is high.
  - If both enables are set, the request is treated as a store.
  - On accept, `addr`, `memOP`, `wdata` and the op type are registered, then the FSM goes to REQ.
  - A request with neither enable set is ignored.
- REQ: `mem_req_valid`=1 with stable fields. On `mem_req_ready`, go to WAIT.
- WAIT:
  - On `mem_rsp_valid`, register the extended result and go to RESP.
  - `mem_rsp_valid` in any other state is ignored.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Store lanes, with o = `addr[1:0]`:
  - B: mask `4'b0001<<o`, data `{4{wdata[7:0]}}`.
  - H: mask `4'b0011<<{o[1],1'b0}`, data `{2{wdata[15:0]}}`.
  - W: mask `4'b1111`, data `wdata`.
- Load extraction:
  - B and BU select byte `mem_rdata[8*o +: 8]`.
  - H and HU select half `mem_rdata[16*o[1] +: 16]`.
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
- Illegal `memOP` (011, 110, 111): access proceeds as W.

## Timing
- Reset values: FSM=IDLE; `req_ready`=1; every other output is 0; internal registers are 0.
- Latency with zero-wait memory:
  - accept at cycle 0;
  - `mem_req_valid` at cycle 1;
  - handshake at cycle 1;
  - `mem_rsp_valid` at cycle 2;
  - `resp_valid` at cycle 3.
- Minimum issue interval is 4 cycles.
- While `mem_req_ready` is low, the unit holds `mem_req_valid` and all `mem_*` fields unchanged.
- Reset asserted in any state returns the FSM to IDLE immediately with outputs at reset values. A bus response still in flight when reset is released is ignored.
- `resp_rdata` and `resp_err` are valid only while `resp_valid` is high.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0, is misaligned.
  - A misaligned request skips the bus and goes IDLE→RESP directly, so `resp_valid` is high 1 cycle after accept.
  - The response carries `resp_err`=1 and `resp_rdata`=0.
  - No `mem_req_valid` is ever issued for it.
- Undefined:
  - `resp_err` is tied to 0.
  - Misaligned low address bits are dropped: H uses `addr[1]` only, W ignores `addr[1:0]`.

## Structure
- `lsu_pkg`: FSM state enum; memOP constants `MEMOP_B/H/W/BU/HU`; the lane mask function.
- One combinational sub-module, `load_align`: takes (`mem_rdata`, offset, `memOP`) and produces the extended result. The top level holds the FSM and the store lane logic.

## Test plan
- SB: addr 0x80000003, wdata 0x12345678 → `mem_wmask`=4'b1000, `mem_wdata`=0x78787878, `mem_addr`=0x80000000, `mem_we`=1; `resp_valid` at cycle 3 with `resp_rdata`=0.
- LB / LBU: addr 0x1, `mem_rdata`=0x00008000 → LB returns 0xFFFFFF80; LBU returns 0x00000080.
- LH / LHU: addr 0x2, `mem_rdata`=0x80010000 → LH returns 0xFFFF8001; LHU returns 0x00008001. LW: addr 0x4 → returns `mem_rdata` unchanged.
- Backpressure: `mem_req_ready` low for 3 cycles → `mem_req_valid` and all fields stay stable; `resp_valid` moves out to cycle 6; `req_ready` stays 0 until RESP has completed.
- Misaligned LW at addr 0x2 with `LSU_MISALIGN_CHECK_EN` defined → no `mem_req_valid`; `resp_valid` and `resp_err` high at cycle 1. Without the macro → `mem_addr`=0x0, normal completion.
- Reset in WAIT, then a stray `mem_rsp_valid` after release → no `resp_valid`; `req_ready`=1; the next LW completes normally.
